connector_merge_rr: RTL and testbench

//  Downstream stage of the three connector ports (p0/p1/p2): buffers each port's valid/8-bit data

---
 rtl/connector_pkg.sv | 11 +
 rtl/connector_merge_rr_if.sv | 26 ++
 rtl/connector_fifo.sv | 47 ++++
 rtl/connector_merge_rr.sv | 80 ++++++++
 tb/tb_connector_merge_rr.sv | 184 ++++++++++++++++++
 5 files changed

// File: rtl/connector_pkg.sv
// Shared types and helpers for the three-port connector merge stage.
package connector_pkg;
  localparam int NPORTS = 3;

  typedef logic [1:0] port_id_t;

  // Round-robin successor over ports 0..NPORTS-1.
  function automatic port_id_t rr_next(input port_id_t p);
    return (p >= port_id_t'(NPORTS - 1)) ? port_id_t'(0) : port_id_t'(p + 2'd1);
  endfunction
endpackage

// File: rtl/connector_merge_rr_if.sv
// Port-side valid/data streams plus the merged valid/ready output of the merge stage.
interface connector_merge_rr_if #(parameter int DW = 8);
  logic          p0_valid;
  logic [DW-1:0] p0_data;
  logic          p1_valid;
  logic [DW-1:0] p1_data;
  logic          p2_valid;
  logic [DW-1:0] p2_data;
  logic          freeze;
  logic          o_ready;
  logic          o_valid;
  logic [DW-1:0] o_data;
  logic [1:0]    o_port;
  logic [2:0]    ovf;
  logic [2:0]    fill;

  modport master (
    output p0_valid, p0_data, p1_valid, p1_data, p2_valid, p2_data, freeze, o_ready,
    input  o_valid, o_data, o_port, ovf, fill
  );

  modport slave (
    input  p0_valid, p0_data, p1_valid, p1_data, p2_valid, p2_data, freeze, o_ready,
    output o_valid, o_data, o_port, ovf, fill
  );
endinterface

// File: rtl/connector_fifo.sv
// Small per-port FIFO; full is judged before any same-cycle pop, so a push on full is dropped.
module connector_fifo #(
  parameter int DW    = 8,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] din,
  output logic          full,
  output logic          empty,
  output logic [DW-1:0] head
);
  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [AW:0]   count;
  logic          do_push, do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/connector_merge_rr.sv
// Merges three buffered valid-only port streams into one valid/ready stream tagged with source port.
module connector_merge_rr
  import connector_pkg::*;
#(
  parameter int DW    = 8,
  parameter int DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  connector_merge_rr_if.slave  bus
);
  logic [NPORTS-1:0]         in_vld, full, empty, pop;
  logic [NPORTS-1:0][DW-1:0] in_dat, head;

  logic          o_valid_q;
  logic [DW-1:0] o_data_q;
  port_id_t      o_port_q, last, grant, cand;
  logic [2:0]    ovf_q;
  logic          found, take, load;

  assign in_vld = {bus.p2_valid, bus.p1_valid, bus.p0_valid};
  assign in_dat = {bus.p2_data, bus.p1_data, bus.p0_data};

  for (genvar g = 0; g < NPORTS; g++) begin : g_port
    connector_fifo #(.DW(DW), .DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (in_vld[g]),
      .pop   (pop[g]),
      .din   (in_dat[g]),
      .full  (full[g]),
      .empty (empty[g]),
      .head  (head[g])
    );
  end

  // Search last+1, last+2, last; first non-empty FIFO wins.
  always_comb begin
    grant = last;
    found = 1'b0;
    cand  = rr_next(last);
    for (int i = 0; i < NPORTS; i++) begin
      if (!found && !empty[cand]) begin
        grant = cand;
        found = 1'b1;
      end
      cand = rr_next(cand);
    end
    take = !o_valid_q || bus.o_ready;
    load = take && !bus.freeze && found;
    pop  = '0;
    if (load) pop[grant] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      o_valid_q <= 1'b0;
      o_data_q  <= '0;
      o_port_q  <= '0;
      last      <= port_id_t'(NPORTS - 1);
      ovf_q     <= '0;
    end else begin
      ovf_q <= ovf_q | (in_vld & full);
      if (load) begin
        o_valid_q <= 1'b1;
        o_data_q  <= head[grant];
        o_port_q  <= grant;
        last      <= grant;
      end else if (take) begin
        o_valid_q <= 1'b0;
      end
    end
  end

  assign bus.o_valid = o_valid_q;
  assign bus.o_data  = o_data_q;
  assign bus.o_port  = o_port_q;
  assign bus.ovf     = ovf_q;
  assign bus.fill    = ~empty;
endmodule

// File: tb/tb_connector_merge_rr.sv
// Directed bench for connector_merge_rr: reset, single word, fairness, backpressure, freeze, mid-stream reset.
module tb_connector_merge_rr;
  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  connector_merge_rr_if #(.DW(8)) bus ();

  connector_merge_rr #(.DW(8), .DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.p0_valid = 1'b0; bus.p0_data = '0;
    bus.p1_valid = 1'b0; bus.p1_data = '0;
    bus.p2_valid = 1'b0; bus.p2_data = '0;
  endtask

  task automatic push_all(input logic [7:0] d0, input logic [7:0] d1, input logic [7:0] d2);
    bus.p0_valid = 1'b1; bus.p0_data = d0;
    bus.p1_valid = 1'b1; bus.p1_data = d1;
    bus.p2_valid = 1'b1; bus.p2_data = d2;
  endtask

  task automatic do_reset();
    idle_inputs();
    bus.freeze = 1'b0;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    idle_inputs();
    bus.freeze  = 1'b0;
    bus.o_ready = 1'b1;

    // Reset state
    do_reset();
    chk("rst_valid", 32'(bus.o_valid), 32'd0);
    chk("rst_data",  32'(bus.o_data),  32'h0);
    chk("rst_port",  32'(bus.o_port),  32'd0);
    chk("rst_ovf",   32'(bus.ovf),     32'h0);
    chk("rst_fill",  32'(bus.fill),    32'h0);

    // Single word on p1: visible two edges later for exactly one cycle
    bus.p1_valid = 1'b1; bus.p1_data = 8'hA5;
    step();
    idle_inputs();
    chk("single_nobypass", 32'(bus.o_valid), 32'd0);
    chk("single_fill",     32'(bus.fill),    32'b010);
    step();
    chk("single_valid", 32'(bus.o_valid), 32'd1);
    chk("single_data",  32'(bus.o_data),  32'hA5);
    chk("single_port",  32'(bus.o_port),  32'd1);
    step();
    chk("single_drop",  32'(bus.o_valid), 32'd0);
    chk("single_empty", 32'(bus.fill),    32'h0);

    // Fairness: three backlogged ports, grants 0,1,2,... with per-port order
    do_reset();
    bus.o_ready = 1'b1;
    for (int c = 0; c < 11; c++) begin
      if (c < 3) push_all(8'(8'h10 + 16*c), 8'(8'h11 + 16*c), 8'(8'h12 + 16*c));
      else idle_inputs();
      step();
      if (c >= 1 && c <= 9) begin
        chk("fair_valid", 32'(bus.o_valid), 32'd1);
        chk("fair_port",  32'(bus.o_port),  32'((c-1) % 3));
        chk("fair_data",  32'(bus.o_data),  32'(8'h10 + 16*((c-1)/3) + (c-1)%3));
      end
    end
    chk("fair_idle", 32'(bus.o_valid), 32'd0);

    // Backpressure on p0: D0 held, D1..D4 buffered, D5 dropped
    do_reset();
    bus.o_ready = 1'b0;
    for (int k = 0; k < 6; k++) begin
      bus.p0_valid = 1'b1; bus.p0_data = 8'(8'h30 + k);
      step();
    end
    chk("bp_ovf",  32'(bus.ovf),     32'b001);
    chk("bp_fill", 32'(bus.fill),    32'b001);
    chk("bp_hold", 32'(bus.o_data),  32'h30);
    chk("bp_vld",  32'(bus.o_valid), 32'd1);
    // Push on a full FIFO that pops this same cycle is still dropped
    bus.o_ready = 1'b1;
    bus.p0_data = 8'h36;
    step();
    idle_inputs();
    chk("bp_d1", 32'(bus.o_data), 32'h31);
    step();
    chk("bp_d2", 32'(bus.o_data), 32'h32);
    step();
    chk("bp_d3", 32'(bus.o_data), 32'h33);
    step();
    chk("bp_d4",    32'(bus.o_data),  32'h34);
    chk("bp_d4vld", 32'(bus.o_valid), 32'd1);
    step();
    chk("bp_done",     32'(bus.o_valid), 32'd0);
    chk("bp_fill_end", 32'(bus.fill),    32'h0);
    chk("bp_sticky",   32'(bus.ovf),     32'b001);

    // Freeze: held word completes, then output idles while p2 keeps data
    do_reset();
    bus.o_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      bus.p2_valid = 1'b1; bus.p2_data = 8'(8'hE0 + k);
      step();
    end
    idle_inputs();
    chk("frz_held", 32'(bus.o_data), 32'hE0);
    bus.freeze  = 1'b1;
    bus.o_ready = 1'b1;
    step();
    chk("frz_drop", 32'(bus.o_valid), 32'd0);
    chk("frz_fill", 32'(bus.fill),    32'b100);
    step();
    chk("frz_stay", 32'(bus.o_valid), 32'd0);
    bus.freeze = 1'b0;
    step();
    chk("frz_e1",   32'(bus.o_data),  32'hE1);
    chk("frz_e1p",  32'(bus.o_port),  32'd2);
    step();
    chk("frz_e2",   32'(bus.o_data),  32'hE2);
    chk("frz_e2v",  32'(bus.o_valid), 32'd1);
    step();
    chk("frz_end",  32'(bus.o_valid), 32'd0);

    // Mid-stream reset with all FIFOs full and overflow flagged
    do_reset();
    bus.o_ready = 1'b0;
    for (int k = 0; k < 6; k++) begin
      push_all(8'(8'h40 + k), 8'(8'h48 + k), 8'(8'h50 + k));
      step();
    end
    idle_inputs();
    chk("mid_ovf",  32'(bus.ovf),    32'b111);
    chk("mid_fill", 32'(bus.fill),   32'b111);
    chk("mid_port", 32'(bus.o_port), 32'd0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_valid", 32'(bus.o_valid), 32'd0);
    chk("mid_rst_fill",  32'(bus.fill),    32'h0);
    chk("mid_rst_ovf",   32'(bus.ovf),     32'h0);
    chk("mid_rst_data",  32'(bus.o_data),  32'h0);
    bus.o_ready = 1'b1;
    push_all(8'h51, 8'h52, 8'h53);
    step();
    idle_inputs();
    step();
    chk("post_p0", 32'(bus.o_port), 32'd0);
    chk("post_d0", 32'(bus.o_data), 32'h51);
    step();
    chk("post_p1", 32'(bus.o_port), 32'd1);
    chk("post_d1", 32'(bus.o_data), 32'h52);
    step();
    chk("post_p2", 32'(bus.o_port), 32'd2);
    chk("post_d2", 32'(bus.o_data), 32'h53);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
